regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file: next-generation GPR array for the MIPS core.
//  - Adds N combinational read ports and two posedge write ports: A = ALU/execute, B = load/late return.
//  - Adds per-register write-through bypass and a busy scoreboard, so issue logic can stall on
//    registers with an outstanding multi-cycle write (loads).
//  - Sits between decode (read addresses) and writeback; replaces the single-write negedge file.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    3   number of read ports
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes and busy-set
//  BYPASS    1   1: same-cycle write data and busy-clear are forwarded to read ports
// PORTS
//  clk      in   1              clock; all state updates on rising edge
//  rst      in   1              synchronous reset, active-high
//  rd_addr  in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy  out  NUM_RD         1 = register on port k has a pending port-B write
//  any_busy out  1              OR of rd_busy; stall request to issue logic
//  wa_en    in   1              port A write enable
//  wa_addr  in   ADDR_W         port A write address
//  wa_data  in   DATA_W         port A write data
//  wb_en    in   1              port B write enable; also clears busy[wb_addr]
//  wb_addr  in   ADDR_W         port B write address
//  wb_data  in   DATA_W         port B write data
//  sb_set   in   1              mark sb_addr busy; issued with a load
//  sb_addr  in   ADDR_W         register to mark busy
// BEHAVIOUR
//  - Reset: rst high at a rising edge clears all DEPTH registers and busy bits to 0.
//    - Writes and sb_set in that cycle are ignored.
//    - Bypass is disabled while rst is high; reads return the array contents.
//  - Writes take effect at the rising edge; storage is visible on the next cycle.
//  - Read path is combinational, zero latency.
//  - Read priority, BYPASS=1:
//    1. ZERO_REG and addr==0 -> 0.
//    2. wa_en and wa_addr==addr -> wa_data.
//    3. wb_en and wb_addr==addr -> wb_data.
//    4. Otherwise the array.
//    BYPASS=0: ZERO_REG check, then array only.
//  - Write collision (wa_en and wb_en, same address): port A data is stored, port B data is
//    dropped, and busy is still cleared by B.
//  - Busy scoreboard, one bit per register, next-state priority:
//    1. ZERO_REG and addr 0 -> bit stays 0.
//    2. sb_set and sb_addr==r -> 1. Set beats clear, so a new load issued the same cycle the
//       old one returns keeps the register busy.
//    3. wb_en and wb_addr==r -> 0.
//    4. Otherwise hold.
//  - A port-A write to a busy register updates data and leaves busy unchanged. WAW avoidance
//    is issue logic's responsibility.
//  - rd_busy[k] = busy[rd_addr_k]. With BYPASS=1 it reads 0 when wb_en and wb_addr==rd_addr_k,
//    unless sb_set targets the same address that cycle. Register 0 never reports busy when
//    ZERO_REG=1.
//  - ZERO_REG=0: register 0 is an ordinary register.
//  - Addresses are always in range (DEPTH = 2**ADDR_W); no wrap handling needed.
// TESTING
//  - Reset: pre-load r5=0xDEAD_BEEF with busy set; 1 cycle rst -> all rd_data 0, rd_busy 0,
//    any_busy 0.
//  - Write then read: wa r3=0x1234_5678. Same cycle, rd port0=3 -> 0x1234_5678 (bypass).
//    Next cycle, with wa_en low -> 0x1234_5678 from the array.
//    With BYPASS=0, the same-cycle read returns the old value 0.
//  - Zero reg: wa r0=0xFFFF_FFFF plus sb_set r0 -> rd r0 = 0 and rd_busy 0, both that cycle
//    and the next.
//  - Collision: wa r7=0xAAAA_AAAA and wb r7=0x5555_5555 same edge -> r7 reads 0xAAAA_AAAA
//    next cycle.
//  - Scoreboard: sb_set r9 -> rd_busy=1 and any_busy=1 on the following cycles.
//    wb r9=0x0000_00C0 -> rd_busy=0 and data=0xC0 in that same cycle, and still after the edge.
//  - Set/clear race: wb r9 and sb_set r9 same edge -> r9 data updated and busy stays 1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file bus: decode-side read ports, two writeback ports and the busy scoreboard set.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 3
);

  // Read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     any_busy;

  // Port A: ALU / execute writeback
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;

  // Port B: load / late return; also retires the busy bit
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;

  // Scoreboard set, issued alongside a load
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;

  modport master (
    output rd_addr,
    output wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output sb_set, sb_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr,
    input  wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  sb_set, sb_addr,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports, two rising-edge write ports (A = execute,
// B = load return), optional write-through bypass and a per-register busy scoreboard used by
// issue logic to stall on registers with an outstanding load.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst,
  regfile_mp_if.slave io_bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [DEPTH-1:0]         w_busy_d;

  // Write/set requests after masking off the hard-wired zero register
  logic                     w_wa_ok;
  logic                     w_wb_ok;
  logic                     w_sb_ok;
  // Port B loses the storage slot when port A writes the same register
  logic                     w_wb_store;
  // Forwarding is suppressed during reset so reads show the (clearing) array
  logic                     w_byp_en;

  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  assign w_wa_ok    = io_bus.wa_en  && !(ZERO_REG && (io_bus.wa_addr == '0));
  assign w_wb_ok    = io_bus.wb_en  && !(ZERO_REG && (io_bus.wb_addr == '0));
  assign w_sb_ok    = io_bus.sb_set && !(ZERO_REG && (io_bus.sb_addr == '0));
  assign w_wb_store = w_wb_ok && !(w_wa_ok && (io_bus.wa_addr == io_bus.wb_addr));
  assign w_byp_en   = BYPASS && !i_rst;

  // Read data for one address: zero register, then port A, then port B, then storage.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (ZERO_REG && (a == '0)) begin
      v = '0;
    end else if (w_byp_en && io_bus.wa_en && (io_bus.wa_addr == a)) begin
      v = io_bus.wa_data;
    end else if (w_byp_en && io_bus.wb_en && (io_bus.wb_addr == a)) begin
      v = io_bus.wb_data;
    end else begin
      v = r_mem[a];
    end
    return v;
  endfunction

  // Busy view for one address: a returning load hides busy unless a new load re-arms it.
  function automatic logic read_busy(input logic [ADDR_W-1:0] a);
    logic v;
    if (ZERO_REG && (a == '0)) begin
      v = 1'b0;
    end else if (w_byp_en && io_bus.wb_en && (io_bus.wb_addr == a) &&
                 !(io_bus.sb_set && (io_bus.sb_addr == a))) begin
      v = 1'b0;
    end else begin
      v = r_busy[a];
    end
    return v;
  endfunction

  // Scoreboard next state: set beats clear so back-to-back loads keep the register busy.
  always_comb begin
    w_busy_d = r_busy;
    if (w_wb_ok) begin
      w_busy_d[io_bus.wb_addr] = 1'b0;
    end
    if (w_sb_ok) begin
      w_busy_d[io_bus.sb_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      w_busy_d[0] = 1'b0;
    end
  end

  // Storage and scoreboard update; reset clears everything and discards same-cycle requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wb_store) begin
        r_mem[io_bus.wb_addr] <= io_bus.wb_data;
      end
      if (w_wa_ok) begin
        r_mem[io_bus.wa_addr] <= io_bus.wa_data;
      end
      r_busy <= w_busy_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      w_rd_data[k*DATA_W +: DATA_W] = read_word(io_bus.rd_addr[k*ADDR_W +: ADDR_W]);
      w_rd_busy[k]                  = read_busy(io_bus.rd_addr[k*ADDR_W +: ADDR_W]);
    end
  end

  assign io_bus.rd_data  = w_rd_data;
  assign io_bus.rd_busy  = w_rd_busy;
  assign io_bus.any_busy = |w_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing instance and a non-bypassing instance share one input bus
// and are compared against an array-based model of the register file.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_nb ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u_dut_nb (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_nb)
  );

  assign bus_nb.rd_addr = bus.rd_addr;
  assign bus_nb.wa_en   = bus.wa_en;
  assign bus_nb.wa_addr = bus.wa_addr;
  assign bus_nb.wa_data = bus.wa_data;
  assign bus_nb.wb_en   = bus.wb_en;
  assign bus_nb.wb_addr = bus.wb_addr;
  assign bus_nb.wb_data = bus.wb_data;
  assign bus_nb.sb_set  = bus.sb_set;
  assign bus_nb.sb_addr = bus.sb_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain storage plus a busy flag per register
  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];

  function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && !rst && bus.wa_en && (int'(bus.wa_addr) == a)) return bus.wa_data;
    if (byp && !rst && bus.wb_en && (int'(bus.wb_addr) == a)) return bus.wb_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && !rst && bus.wb_en && (int'(bus.wb_addr) == a) &&
        !(bus.sb_set && (int'(bus.sb_addr) == a))) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply one clock edge to the model using the inputs currently on the bus.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.wb_en) m_mem[bus.wb_addr] = bus.wb_data;
      if (bus.wa_en) m_mem[bus.wa_addr] = bus.wa_data;  // A overwrites B on collision
      if (bus.wb_en) m_busy[bus.wb_addr] = 1'b0;
      if (bus.sb_set) m_busy[bus.sb_addr] = 1'b1;       // set beats clear
      m_mem[0]  = '0;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic any_b;
    logic any_nb;
    any_b  = 1'b0;
    any_nb = 1'b0;
    for (int k = 0; k < int'(NR); k++) begin
      int a;
      a = int'(bus.rd_addr[k*AW +: AW]);
      chk($sformatf("%s_byp_data%0d", tag, k), bus.rd_data[k*DW +: DW], exp_data(a, 1'b1));
      chk($sformatf("%s_byp_busy%0d", tag, k), DW'(bus.rd_busy[k]), DW'(exp_busy(a, 1'b1)));
      chk($sformatf("%s_nb_data%0d", tag, k), bus_nb.rd_data[k*DW +: DW], exp_data(a, 1'b0));
      chk($sformatf("%s_nb_busy%0d", tag, k), DW'(bus_nb.rd_busy[k]), DW'(exp_busy(a, 1'b0)));
      any_b  = any_b  | exp_busy(a, 1'b1);
      any_nb = any_nb | exp_busy(a, 1'b0);
    end
    chk({tag, "_byp_any"}, DW'(bus.any_busy), DW'(any_b));
    chk({tag, "_nb_any"}, DW'(bus_nb.any_busy), DW'(any_nb));
  endtask

  task automatic idle();
    bus.wa_en  = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en  = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    bus.rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 'x;
      m_busy[i] = 1'b0;
    end
    idle();
    set_rd(0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Pre-load r5 with data and a pending load, then reset with requests that must be ignored
    bus.wa_en = 1'b1; bus.wa_addr = 5; bus.wa_data = 32'hDEAD_BEEF;
    bus.sb_set = 1'b1; bus.sb_addr = 5;
    tick();
    idle();
    set_rd(5, 6, 0);
    #1;
    chk("preload_data", bus.rd_data[DW-1:0], 32'hDEAD_BEEF);
    chk("preload_busy", DW'(bus.rd_busy[0]), 32'd1);
    rst = 1'b1;
    bus.wa_en = 1'b1; bus.wa_addr = 6; bus.wa_data = 32'h0BAD_F00D;
    bus.sb_set = 1'b1; bus.sb_addr = 6;
    #1;
    chk("rst_nobypass", bus.rd_data[2*DW-1:DW], 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_data5", bus.rd_data[DW-1:0], 32'd0);
    chk("rst_data6", bus.rd_data[2*DW-1:DW], 32'd0);
    chk("rst_busy", DW'(bus.rd_busy), 32'd0);
    chk("rst_any", DW'(bus.any_busy), 32'd0);
    check_all("rst");

    // Write-through vs. array read
    bus.wa_en = 1'b1; bus.wa_addr = 3; bus.wa_data = 32'h1234_5678;
    set_rd(3, 3, 3);
    #1;
    chk("wt_bypass", bus.rd_data[DW-1:0], 32'h1234_5678);
    chk("wt_nobypass", bus_nb.rd_data[DW-1:0], 32'd0);
    check_all("wt_same");
    tick();
    idle();
    #1;
    chk("wt_array", bus.rd_data[DW-1:0], 32'h1234_5678);
    chk("wt_array_nb", bus_nb.rd_data[DW-1:0], 32'h1234_5678);

    // Register 0 ignores writes and busy-set
    bus.wa_en = 1'b1; bus.wa_addr = 0; bus.wa_data = 32'hFFFF_FFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 0;
    set_rd(0, 0, 0);
    #1;
    chk("zero_data_same", bus.rd_data[DW-1:0], 32'd0);
    chk("zero_busy_same", DW'(bus.rd_busy[0]), 32'd0);
    tick();
    idle();
    #1;
    chk("zero_data_next", bus.rd_data[DW-1:0], 32'd0);
    chk("zero_busy_next", DW'(bus.any_busy), 32'd0);

    // Same-edge collision: port A data kept
    bus.wa_en = 1'b1; bus.wa_addr = 7; bus.wa_data = 32'hAAAA_AAAA;
    bus.wb_en = 1'b1; bus.wb_addr = 7; bus.wb_data = 32'h5555_5555;
    set_rd(7, 0, 0);
    tick();
    idle();
    #1;
    chk("collision", bus.rd_data[DW-1:0], 32'hAAAA_AAAA);

    // Scoreboard set then retire by a port-B write
    bus.sb_set = 1'b1; bus.sb_addr = 9;
    set_rd(9, 1, 2);
    tick();
    idle();
    #1;
    chk("sb_busy", DW'(bus.rd_busy[0]), 32'd1);
    chk("sb_any", DW'(bus.any_busy), 32'd1);
    tick();
    chk("sb_busy_hold", DW'(bus.rd_busy[0]), 32'd1);
    bus.wb_en = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'h0000_00C0;
    #1;
    chk("sb_clr_busy", DW'(bus.rd_busy[0]), 32'd0);
    chk("sb_clr_any", DW'(bus.any_busy), 32'd0);
    chk("sb_clr_data", bus.rd_data[DW-1:0], 32'h0000_00C0);
    chk("sb_clr_nb_busy", DW'(bus_nb.rd_busy[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("sb_after_busy", DW'(bus.rd_busy[0]), 32'd0);
    chk("sb_after_data", bus.rd_data[DW-1:0], 32'h0000_00C0);

    // Set/clear race on r9
    bus.sb_set = 1'b1; bus.sb_addr = 9;
    tick();
    bus.sb_set = 1'b1; bus.sb_addr = 9;
    bus.wb_en = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'h0000_0123;
    #1;
    chk("race_busy_same", DW'(bus.rd_busy[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("race_busy", DW'(bus.rd_busy[0]), 32'd1);
    chk("race_data", bus.rd_data[DW-1:0], 32'h0000_0123);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      bus.wa_en   = 1'($urandom_range(0, 1));
      bus.wa_addr = AW'(rnd_addr());
      bus.wa_data = $urandom;
      bus.wb_en   = 1'($urandom_range(0, 2) == 0);
      bus.wb_addr = AW'(rnd_addr());
      bus.wb_data = $urandom;
      bus.sb_set  = 1'($urandom_range(0, 2) == 0);
      bus.sb_addr = AW'(rnd_addr());
      set_rd(rnd_addr(), rnd_addr(), rnd_addr());
      #1;
      check_all("rand");
      tick();
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
